rom_multi_reader: RTL and testbench

//  Parametrised successor of the per-chip rom_reader: one sequencer serving CHIP_COUNT PROM sockets on a shared address/data bus.

---
 rtl/rom_multi_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 tb/tb_rom_multi_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_multi_reader.sv
// -----------------------------------------------------------------------------
// rom_multi_reader
//
// One read sequencer shared by CHIP_COUNT PROM sockets on a common address and
// data bus.
//
// Operating modes:
//   - Manual mode: increment/decrement pulses step through the address space one
//     word at a time.
//   - Auto mode: a start pulse dumps the whole chip from address 0 to
//     last_address.
//
// Every read follows the same sequence:
//   1. Drive the address and the active-low chip select.
//   2. Wait SETTLE_CYCLES clocks for the bus to settle.
//   3. Sample chip_data_in for one clock.
//   4. Present the word on a valid/ready stream.
//
// Optional feature (macro ROM_MULTI_READER_CHECKSUM_EN):
//   When the macro is defined, an auto dump adds one trailing beat. That beat
//   carries the modulo-2^DATA_WIDTH sum of all transferred words, with
//   data_address set to all ones and checksum_flag set to 1. When the macro is
//   undefined, checksum_flag stays 0.
//
// Ports:
//   clk, reset_n       board clock, asynchronous active-low reset
//   chip_index         socket to read, latched when an operation starts
//   last_address       highest valid address of the chip, latched at start
//   mode               0 = manual step, 1 = auto dump
//   start              auto dump start pulse
//   increment_address  manual +1 pulse
//   decrement_address  manual -1 pulse
//   chip_data_in       shared chip data bus
//   chip_address       shared chip address bus
//   chip_select_n      one-hot active-low chip enables
//   data_out           sampled word
//   data_address       address of data_out
//   data_valid         stream valid
//   data_ready         stream ready
//   checksum_flag      current beat is the checksum beat
//   busy               sequencer not idle
//   done               one-cycle pulse at the end of an auto dump
// -----------------------------------------------------------------------------
module rom_multi_reader #(
    parameter int CHIP_COUNT       = 2,
    parameter int CHIP_INDEX_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 9,
    parameter int DATA_WIDTH       = 8,
    parameter int SETTLE_CYCLES    = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CHIP_INDEX_WIDTH-1:0] chip_index,
    input  logic [ADDRESS_WIDTH-1:0]    last_address,
    input  logic                        mode,
    input  logic                        start,
    input  logic                        increment_address,
    input  logic                        decrement_address,
    input  logic [DATA_WIDTH-1:0]       chip_data_in,
    output logic [ADDRESS_WIDTH-1:0]    chip_address,
    output logic [CHIP_COUNT-1:0]       chip_select_n,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [ADDRESS_WIDTH-1:0]    data_address,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        checksum_flag,
    output logic                        busy,
    output logic                        done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONES = {ADDRESS_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]    DATA_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [CHIP_COUNT-1:0]    SEL_IDLE  = {CHIP_COUNT{1'b1}};
    localparam logic [CHIP_COUNT-1:0]    SEL_ONE   = CHIP_COUNT'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_OUTPUT   = 3'd3,
        ST_NEXT     = 3'd4,
        ST_CHECKSUM = 3'd5
    } state_t;

    // Next address going up, wrapping from lim back to 0.
    function automatic logic [ADDRESS_WIDTH-1:0] step_up(
        input logic [ADDRESS_WIDTH-1:0] a,
        input logic [ADDRESS_WIDTH-1:0] lim
    );
        return (a == lim) ? ADDR_ZERO : a + ADDRESS_WIDTH'(1);
    endfunction

    // Next address going down, wrapping from 0 to lim.
    function automatic logic [ADDRESS_WIDTH-1:0] step_down(
        input logic [ADDRESS_WIDTH-1:0] a,
        input logic [ADDRESS_WIDTH-1:0] lim
    );
        return (a == ADDR_ZERO) ? lim : a - ADDRESS_WIDTH'(1);
    endfunction

    // One-hot select for an index. An index beyond CHIP_COUNT shifts the bit
    // out of the vector, so no socket is selected.
    function automatic logic [CHIP_COUNT-1:0] onehot(
        input logic [CHIP_INDEX_WIDTH-1:0] idx
    );
        return SEL_ONE << idx;
    endfunction

    state_t                      state_r, state_s;
    logic [ADDRESS_WIDTH-1:0]    addr_r, addr_s;
    logic [CHIP_INDEX_WIDTH-1:0] idx_r, idx_s;
    logic [ADDRESS_WIDTH-1:0]    last_r, last_s;
    logic                        auto_r, auto_s;
    logic [CNT_W-1:0]            cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0]       data_out_r, data_out_s;
    logic [ADDRESS_WIDTH-1:0]    data_address_r, data_address_s;
    logic                        valid_r, valid_s;
    logic                        done_r, done_s;
    logic                        flag_r, flag_s;
    logic [CHIP_COUNT-1:0]       cs_n_r, cs_n_s;
    logic                        busy_r, busy_s;
    logic                        step_req_s;
    logic                        idx_valid_s;
    logic                        at_last_s;
`ifdef ROM_MULTI_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]       sum_r, sum_s;
`endif

    // A manual step needs exactly one of increment/decrement; both together cancel.
    assign step_req_s  = ~mode & (increment_address ^ decrement_address);
    assign idx_valid_s = |onehot(idx_r);
    assign at_last_s   = (addr_r == last_r);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mode && start) begin
                    state_s = ST_SETTLE;
                end else if (step_req_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                state_s = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (data_ready) begin
                    state_s = auto_r ? ST_NEXT : ST_IDLE;
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            ST_NEXT: begin
                if (at_last_s) begin
`ifdef ROM_MULTI_READER_CHECKSUM_EN
                    state_s = ST_CHECKSUM;
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_CHECKSUM: begin
                if (data_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CHECKSUM;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and datapath register.
    always_comb begin
        addr_s         = addr_r;
        idx_s          = idx_r;
        last_s         = last_r;
        auto_s         = auto_r;
        cnt_s          = cnt_r;
        data_out_s     = data_out_r;
        data_address_s = data_address_r;
        valid_s        = valid_r;
        done_s         = 1'b0;
        flag_s         = flag_r;
`ifdef ROM_MULTI_READER_CHECKSUM_EN
        sum_s          = sum_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (mode && start) begin
                    idx_s  = chip_index;
                    last_s = last_address;
                    auto_s = 1'b1;
                    addr_s = ADDR_ZERO;
                    cnt_s  = {CNT_W{1'b0}};
`ifdef ROM_MULTI_READER_CHECKSUM_EN
                    sum_s  = DATA_ZERO;
`endif
                end else if (step_req_s) begin
                    idx_s  = chip_index;
                    last_s = last_address;
                    auto_s = 1'b0;
                    cnt_s  = {CNT_W{1'b0}};
                    // A stale address above a newly lowered limit restarts at 0.
                    if (addr_r > last_address) begin
                        addr_s = ADDR_ZERO;
                    end else if (increment_address) begin
                        addr_s = step_up(addr_r, last_address);
                    end else begin
                        addr_s = step_down(addr_r, last_address);
                    end
                end else begin
                    addr_s = addr_r;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                // An empty or invalid socket reads as all ones, like an undriven bus.
                data_out_s     = idx_valid_s ? chip_data_in : DATA_ONES;
                data_address_s = addr_r;
                valid_s        = 1'b1;
            end
            ST_OUTPUT: begin
                if (data_ready) begin
                    valid_s = 1'b0;
`ifdef ROM_MULTI_READER_CHECKSUM_EN
                    sum_s   = sum_r + data_out_r;
`else
                    // The done pulse lines up with the cycle after the final transfer.
                    done_s  = auto_r & at_last_s;
`endif
                end else begin
                    valid_s = 1'b1;
                end
            end
            ST_NEXT: begin
                if (at_last_s) begin
`ifdef ROM_MULTI_READER_CHECKSUM_EN
                    data_out_s     = sum_r;
                    data_address_s = ADDR_ONES;
                    valid_s        = 1'b1;
                    flag_s         = 1'b1;
`else
                    valid_s        = 1'b0;
`endif
                end else begin
                    addr_s = addr_r + ADDRESS_WIDTH'(1);
                    cnt_s  = {CNT_W{1'b0}};
                end
            end
            ST_CHECKSUM: begin
                if (data_ready) begin
                    valid_s = 1'b0;
                    flag_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                valid_s = 1'b0;
                flag_s  = 1'b0;
            end
        endcase
    end

    // Select and busy follow the state being entered so they line up with the address.
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        if ((state_s == ST_SETTLE) || (state_s == ST_SAMPLE) || (state_s == ST_OUTPUT)) begin
            cs_n_s = ~onehot(idx_s);
        end else begin
            cs_n_s = SEL_IDLE;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r         <= ADDR_ZERO;
            idx_r          <= {CHIP_INDEX_WIDTH{1'b0}};
            last_r         <= ADDR_ZERO;
            auto_r         <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            data_out_r     <= DATA_ZERO;
            data_address_r <= ADDR_ZERO;
            valid_r        <= 1'b0;
            done_r         <= 1'b0;
            flag_r         <= 1'b0;
            cs_n_r         <= SEL_IDLE;
            busy_r         <= 1'b0;
        end else begin
            addr_r         <= addr_s;
            idx_r          <= idx_s;
            last_r         <= last_s;
            auto_r         <= auto_s;
            cnt_r          <= cnt_s;
            data_out_r     <= data_out_s;
            data_address_r <= data_address_s;
            valid_r        <= valid_s;
            done_r         <= done_s;
            flag_r         <= flag_s;
            cs_n_r         <= cs_n_s;
            busy_r         <= busy_s;
        end
    end

`ifdef ROM_MULTI_READER_CHECKSUM_EN
    // Checksum accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= DATA_ZERO;
        end else begin
            sum_r <= sum_s;
        end
    end
`endif

    assign chip_address  = addr_r;
    assign chip_select_n = cs_n_r;
    assign data_out      = data_out_r;
    assign data_address  = data_address_r;
    assign data_valid    = valid_r;
    assign checksum_flag = flag_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_rom_multi_reader.sv
module tb_rom_multi_reader;

    localparam int CC = 2;
    localparam int IW = 2;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int SC = 4;

    logic          clk;
    logic          reset_n;
    logic [IW-1:0] chip_index;
    logic [AW-1:0] last_address;
    logic          mode;
    logic          start;
    logic          increment_address;
    logic          decrement_address;
    logic [DW-1:0] chip_data_in;
    logic [AW-1:0] chip_address;
    logic [CC-1:0] chip_select_n;
    logic [DW-1:0] data_out;
    logic [AW-1:0] data_address;
    logic          data_valid;
    logic          data_ready;
    logic          checksum_flag;
    logic          busy;
    logic          done;

    int check_count = 0;
    int error_count = 0;

    rom_multi_reader #(
        .CHIP_COUNT      (CC),
        .CHIP_INDEX_WIDTH(IW),
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .SETTLE_CYCLES   (SC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .chip_index       (chip_index),
        .last_address     (last_address),
        .mode             (mode),
        .start            (start),
        .increment_address(increment_address),
        .decrement_address(decrement_address),
        .chip_data_in     (chip_data_in),
        .chip_address     (chip_address),
        .chip_select_n    (chip_select_n),
        .data_out         (data_out),
        .data_address     (data_address),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .checksum_flag    (checksum_flag),
        .busy             (busy),
        .done             (done)
    );

    // ROM model: every socket returns the low address byte XOR 0xA5.
    assign chip_data_in = chip_address[7:0] ^ 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo ^ 8'hA5;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for data_valid; cycles is the number of ticks taken.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!data_valid && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_value("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int extra;
        bit stable;
        logic [7:0] exp_sum;

        reset_n = 1'b0;
        chip_index = '0;
        last_address = 9'd511;
        mode = 1'b0;
        start = 1'b0;
        increment_address = 1'b0;
        decrement_address = 1'b0;
        data_ready = 1'b0;
        do_reset();

        // Reset state
        check_value("rst_addr", 32'(chip_address), 32'd0);
        check_value("rst_sel", 32'(chip_select_n), 32'h3);
        check_value("rst_data", 32'(data_out), 32'd0);
        check_value("rst_valid", {31'd0, data_valid}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_done", {31'd0, done}, 32'd0);

        // 1. Manual increment latency and select
        chip_index = 2'd1;
        last_address = 9'd511;
        increment_address = 1'b1;
        tick();
        increment_address = 1'b0;
        check_value("t1_addr", 32'(chip_address), 32'd1);
        check_value("t1_sel", 32'(chip_select_n), 32'h1);
        check_value("t1_busy", {31'd0, busy}, 32'd1);
        wait_valid(n);
        check_value("t1_latency", 32'(n + 1), 32'(SC + 2));
        check_value("t1_data", 32'(data_out), 32'hA4);
        check_value("t1_daddr", 32'(data_address), 32'd1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check_value("t1_valid_drop", {31'd0, data_valid}, 32'd0);
        check_value("t1_idle", {31'd0, busy}, 32'd0);
        check_value("t1_sel_idle", 32'(chip_select_n), 32'h3);

        // 2. Manual wrap both ways
        do_reset();
        last_address = 9'd255;
        decrement_address = 1'b1;
        tick();
        decrement_address = 1'b0;
        check_value("t2_dec_addr", 32'(chip_address), 32'd255);
        wait_valid(n);
        check_value("t2_dec_data", 32'(data_out), 32'h5A);
        check_value("t2_dec_daddr", 32'(data_address), 32'd255);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        increment_address = 1'b1;
        tick();
        increment_address = 1'b0;
        check_value("t2_inc_addr", 32'(chip_address), 32'd0);
        wait_valid(n);
        check_value("t2_inc_data", 32'(data_out), 32'hA5);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;

        // 3. Auto dump of 4 words with ready held high
        mode = 1'b1;
        chip_index = 2'd0;
        last_address = 9'd3;
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_value("t3_sel", 32'(chip_select_n), 32'h2);
        exp_sum = 8'd0;
        for (int b = 0; b < 4; b++) begin
            wait_valid(n);
            check_value("t3_valid", {31'd0, data_valid}, 32'd1);
            check_value("t3_data", 32'(data_out), 32'(rom_word(b)));
            check_value("t3_daddr", 32'(data_address), 32'(b));
            check_value("t3_flag", {31'd0, checksum_flag}, 32'd0);
            exp_sum = exp_sum + rom_word(b);
            tick();
`ifdef ROM_MULTI_READER_CHECKSUM_EN
            check_value("t3_done_early", {31'd0, done}, 32'd0);
`else
            check_value("t3_done", {31'd0, done}, (b == 3) ? 32'd1 : 32'd0);
`endif
        end
`ifdef ROM_MULTI_READER_CHECKSUM_EN
        wait_valid(n);
        check_value("t3_cs_flag", {31'd0, checksum_flag}, 32'd1);
        check_value("t3_cs_data", 32'(data_out), 32'(exp_sum));
        check_value("t3_cs_daddr", 32'(data_address), 32'h1FF);
        tick();
        check_value("t3_cs_done", {31'd0, done}, 32'd1);
`endif
        tick();
        check_value("t3_done_clear", {31'd0, done}, 32'd0);
        check_value("t3_idle", {31'd0, busy}, 32'd0);

        // 4. Back-pressure on beat 2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wait_valid(n);
            check_value("t4_daddr", 32'(data_address), 32'(b));
            check_value("t4_data", 32'(data_out), 32'(rom_word(b)));
            if (b == 2) begin
                data_ready = 1'b0;
                stable = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    if (!data_valid || data_out != rom_word(2) ||
                        data_address != 9'd2 || chip_address != 9'd2)
                        stable = 1'b0;
                end
                check_value("t4_stable", {31'd0, stable}, 32'd1);
                data_ready = 1'b1;
            end
            tick();
        end
        extra = 0;
        n = 0;
        while (busy && n < 200) begin
            if (data_valid && !checksum_flag) extra++;
            tick();
            n++;
        end
        check_value("t4_extra_beats", 32'(extra), 32'd0);
        check_value("t4_end_addr", 32'(chip_address), 32'd3);
        data_ready = 1'b0;

        // 5. Simultaneous inc/dec, inc while busy, invalid index
        mode = 1'b0;
        last_address = 9'd511;
        increment_address = 1'b1;
        decrement_address = 1'b1;
        tick();
        increment_address = 1'b0;
        decrement_address = 1'b0;
        check_value("t5_both_busy", {31'd0, busy}, 32'd0);
        check_value("t5_both_addr", 32'(chip_address), 32'd3);
        increment_address = 1'b1;
        tick();
        increment_address = 1'b0;
        tick();
        increment_address = 1'b1;
        tick();
        increment_address = 1'b0;
        wait_valid(n);
        check_value("t5_busy_daddr", 32'(data_address), 32'd4);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        check_value("t5_no_queue_busy", {31'd0, busy}, 32'd0);
        check_value("t5_no_queue_addr", 32'(chip_address), 32'd4);
        chip_index = 2'd2;
        increment_address = 1'b1;
        tick();
        increment_address = 1'b0;
        check_value("t5_bad_sel", 32'(chip_select_n), 32'h3);
        wait_valid(n);
        check_value("t5_bad_data", 32'(data_out), 32'hFF);
        check_value("t5_bad_daddr", 32'(data_address), 32'd5);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;

        // 6. Async reset during SETTLE of an auto dump
        mode = 1'b1;
        chip_index = 2'd0;
        last_address = 9'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_value("t6_rst_addr", 32'(chip_address), 32'd0);
        check_value("t6_rst_sel", 32'(chip_select_n), 32'h3);
        check_value("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        check_value("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_value("t6_rst_data", 32'(data_out), 32'd0);
        tick();
        tick();
        check_value("t6_no_read", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();
        data_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        check_value("t6_restart_daddr", 32'(data_address), 32'd0);
        check_value("t6_restart_data", 32'(data_out), 32'hA5);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
